sound_arbiter: RTL and testbench
================================

Name: sound_arbiter

Overview:
- Shares the single speaker/debug-LED sound output between three requesters: background song (lowest priority), tie buzzer and round-win jingle (highest priority).
- Sequences the fixed-length tie and win jingles, then returns output ownership to the song.
- Generates the audible square wave itself through an internal tone generator.
- Sits between the round logic (win/tie pulses), the song reader (tone code in, advance pulse out) and the sound output pin.

Parameters:
- HALF_UNIT, 4: clk cycles per tone-code step; half-period of the square wave = tone_code * HALF_UNIT clks.
- NOTE_TICKS, 64: slowen ticks per note, applied to jingle notes and song notes alike.
- GAP_TICKS, 16: slowen ticks of silence after a jingle before the song resumes.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- slowen  in  1  one-clk tick enable from the slow divider
- win_req  in  1  one-clk pulse: round won
- tie_req  in  1  one-clk pulse: tie/false start
- song_en  in  1  level: background song allowed (switch)
- song_tone  in  4  current song tone code; 0 = rest
- song_adv  out  1  one-clk pulse: song reader advances to its next note
- sound  out  1  square-wave output
- grant  out  2  current owner: 0 none, 1 song, 2 tie, 3 win
- busy  out  1  high while a jingle or the gap is active

Behaviour:
- Reset: asynchronous, active-high.
  - State = IDLE; sound, song_adv and busy = 0; grant = 0.
  - Note and tone counters and pending flags are cleared.
  - Reset mid-jingle aborts the jingle with no residue.
- Pending flags:
  - win_req and tie_req pulses set pend_win and pend_tie on the same edge.
  - Flags are consumed at the next state decision, one clk later.
- States: IDLE, SONG, TIE, WIN, GAP.
  - IDLE: grant 0, sound held 0. pend_win -> WIN; else pend_tie -> TIE; else song_en -> SONG.
  - SONG: grant 1; tone = song_tone.
    - Note counter counts slowen ticks; on reaching NOTE_TICKS, song_adv pulses for 1 clk and the counter clears.
    - song_en low -> IDLE next clk with no song_adv pulse.
    - pend_win or pend_tie preempts immediately. The partial note is discarded and song_adv is not pulsed, so the song position is preserved.
  - TIE: grant 2; plays ROM notes {12, 0}, each NOTE_TICKS long.
    - pend_win preempts immediately: enter WIN at note 0 and clear pend_tie.
    - New tie_req is ignored (flag cleared) while in TIE.
    - After the last note -> GAP.
  - WIN: grant 3; plays ROM notes {6, 5, 4, 3}.
    - tie_req and win_req are ignored and their flags cleared; no restart.
    - After the last note -> GAP.
  - GAP: sound 0, grant 0, busy 1; lasts GAP_TICKS slowen ticks.
    - pend_win -> WIN and pend_tie -> TIE, each immediately.
    - At expiry -> SONG if song_en, else IDLE.
- busy = 1 in TIE, WIN and GAP.
- Tone generator:
  - Tone code 0: sound forced 0 and half counter held at 0.
  - Otherwise the counter counts 1..tone*HALF_UNIT, then sound toggles and the counter restarts.
  - A tone code change restarts the counter and keeps the current sound level.
  - Counter width: clog2(15*HALF_UNIT + 1).
- Simultaneous win_req and tie_req: win wins and tie is dropped.
- Request on the same clk as a note boundary: preemption takes precedence and song_adv does not pulse.
- Note and gap counters saturate-compare with ==; no wrap-around beyond NOTE_TICKS.

Decomposition:
- Shared package holds:
  - State encoding constants (IDLE = 0, SONG = 1, TIE = 2, WIN = 3, GAP = 4).
  - Grant codes.
  - Jingle ROM constants: TIE_LEN = 2, WIN_LEN = 4, note tables.
  - Tone code width (4).
- One natural sub-module: tone_gen.
  - Inputs: clk, rst, tone[3:0]. Output: sound.
  - Parameterised by HALF_UNIT.
  - Reused by any future sound source.

Test Plan (HALF_UNIT = 4, NOTE_TICKS = 4, GAP_TICKS = 2, slowen every 4th clk):
- Reset checks:
  - Reset released, song_en = 0 -> grant 0, sound 0, song_adv never pulses over 200 clks.
  - Assert rst mid-WIN -> all outputs 0 within the same cycle.
- Song playback:
  - song_en = 1, song_tone = 3 -> grant 1, sound toggles every 12 clks.
  - song_adv pulses once per 16 clks (4 ticks).
- Win preemption:
  - win_req during SONG -> grant 3 next clk; half-periods 24, 20, 16, 12 clks, 4 ticks each.
  - Then GAP for 2 ticks with grant 0, sound 0, busy 1; then grant 1.
  - No song_adv pulse during the interruption.
- Tie handling:
  - tie_req in IDLE with song_en = 0 -> grant 2: tone 12 (48-clk half-period) for 4 ticks, silence for 4 ticks, GAP, then IDLE.
  - win_req during the TIE silence note -> grant 3 immediately; full 4-note jingle plays.
- Simultaneous requests:
  - win_req and tie_req on the same clk -> WIN only; no TIE follows.
  - tie_req during WIN -> ignored; GAP follows directly.
- Tone 0 rest:
  - song_tone = 0 -> sound stays 0 while song_adv continues every 16 clks.
  - song_tone changes 3 -> 5 -> next toggle 20 clks after the change.

Source files
------------

// File: rtl/sound_arbiter_pkg.sv
// sound_arbiter shared types: state/grant encodings, jingle tables
// and the tone code width.
package sound_arbiter_pkg;

  localparam int TONE_W = 4;
  localparam int IDX_W  = 2;

  typedef logic [TONE_W-1:0] tone_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SONG = 3'd1,
    ST_TIE  = 3'd2,
    ST_WIN  = 3'd3,
    ST_GAP  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    GR_NONE = 2'd0,
    GR_SONG = 2'd1,
    GR_TIE  = 2'd2,
    GR_WIN  = 2'd3
  } grant_e;

  localparam int TIE_LEN = 2;
  localparam int WIN_LEN = 4;

  // Note tables, entry 0 in the low nibble.
  localparam logic [4*TONE_W-1:0] TIE_ROM =
    {4'd0, 4'd0, 4'd0, 4'd12};
  localparam logic [4*TONE_W-1:0] WIN_ROM =
    {4'd3, 4'd4, 4'd5, 4'd6};

  function automatic tone_t rom_tone(
    input logic [4*TONE_W-1:0] rom,
    input logic [IDX_W-1:0]    idx
  );
    return rom[{idx, 2'b00} +: TONE_W];
  endfunction

endpackage

// File: rtl/sound_arbiter_if.sv
// sound_arbiter request/response bundle: round logic pulses,
// song reader link and the sound output.
interface sound_arbiter_if;
  import sound_arbiter_pkg::*;

  logic       slowen;
  logic       win_req;
  logic       tie_req;
  logic       song_en;
  tone_t      song_tone;
  logic       song_adv;
  logic       sound;
  logic [1:0] grant;
  logic       busy;

  modport master (
    output slowen, win_req, tie_req,
    output song_en, song_tone,
    input  song_adv, sound, grant, busy
  );

  modport slave (
    input  slowen, win_req, tie_req,
    input  song_en, song_tone,
    output song_adv, sound, grant, busy
  );

endinterface

// File: rtl/sound_arbiter_tone_gen.sv
// Square-wave generator: half-period = tone * HALF_UNIT clks,
// tone 0 is a rest.
module sound_arbiter_tone_gen
  import sound_arbiter_pkg::*;
#(
  parameter int HALF_UNIT = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  tone_t tone,
  output logic  sound
);

  localparam int CNT_W = $clog2(15 * HALF_UNIT + 1);
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] lim;
  tone_t            tone_q;
  logic             snd_q;

  assign lim = CNT_W'(tone * HALF_UNIT);

  // A code change restarts the half-period but keeps the level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      snd_q  <= 1'b0;
      tone_q <= '0;
    end else begin
      tone_q <= tone;
      if (tone == '0) begin
        cnt   <= '0;
        snd_q <= 1'b0;
      end else if (tone != tone_q) begin
        cnt <= C_ONE;
      end else if (cnt == lim) begin
        cnt   <= C_ONE;
        snd_q <= ~snd_q;
      end else begin
        cnt <= cnt + C_ONE;
      end
    end
  end

  assign sound = snd_q & (tone != '0);

endmodule

// File: rtl/sound_arbiter.sv
// Speaker owner arbitration: song < tie buzzer < win jingle,
// jingle sequencing, post-jingle gap and tone generation.
module sound_arbiter
  import sound_arbiter_pkg::*;
#(
  parameter int HALF_UNIT  = 4,
  parameter int NOTE_TICKS = 64,
  parameter int GAP_TICKS  = 16
) (
  input logic clk,
  input logic rst,
  sound_arbiter_if.slave bus
);

  localparam int TICK_MAX =
    (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
  localparam int TW = $clog2(TICK_MAX + 1);

  localparam logic [TW-1:0] T_ONE     = TW'(1);
  localparam logic [TW-1:0] NOTE_LAST = TW'(NOTE_TICKS - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_TICKS - 1);

  localparam logic [IDX_W-1:0] I_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0] TIE_END = IDX_W'(TIE_LEN - 1);
  localparam logic [IDX_W-1:0] WIN_END = IDX_W'(WIN_LEN - 1);

  state_e           state, state_n;
  logic [TW-1:0]    tick_cnt, tick_cnt_n, tick_inc;
  logic [IDX_W-1:0] note_idx, note_idx_n;
  logic             pend_win, pend_win_n;
  logic             pend_tie, pend_tie_n;
  logic             adv_q, adv_n;
  logic             note_end, gap_end;
  tone_t            tone;
  grant_e           grant;
  logic             busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      tick_cnt <= '0;
      note_idx <= '0;
      pend_win <= 1'b0;
      pend_tie <= 1'b0;
      adv_q    <= 1'b0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_cnt_n;
      note_idx <= note_idx_n;
      pend_win <= pend_win_n;
      pend_tie <= pend_tie_n;
      adv_q    <= adv_n;
    end
  end

  always_comb begin
    state_n    = state;
    tick_cnt_n = tick_cnt;
    note_idx_n = note_idx;
    pend_win_n = pend_win | bus.win_req;
    pend_tie_n = pend_tie | (bus.tie_req & ~bus.win_req);
    adv_n      = 1'b0;
    tone       = '0;
    tick_inc   = bus.slowen ? tick_cnt + T_ONE : tick_cnt;
    note_end   = bus.slowen && (tick_cnt == NOTE_LAST);
    gap_end    = bus.slowen && (tick_cnt == GAP_LAST);

    unique case (state)
      ST_IDLE: begin
        if (pend_win)         state_n = ST_WIN;
        else if (pend_tie)    state_n = ST_TIE;
        else if (bus.song_en) state_n = ST_SONG;
      end
      ST_SONG: begin
        tone = bus.song_tone;
        if (pend_win)          state_n = ST_WIN;
        else if (pend_tie)     state_n = ST_TIE;
        else if (!bus.song_en) state_n = ST_IDLE;
        else if (note_end) begin
          // A request landing on the boundary keeps the song position.
          tick_cnt_n = '0;
          adv_n      = ~(bus.win_req | bus.tie_req);
        end else begin
          tick_cnt_n = tick_inc;
        end
      end
      ST_TIE: begin
        tone       = rom_tone(TIE_ROM, note_idx);
        pend_tie_n = 1'b0;
        if (pend_win) begin
          state_n = ST_WIN;
        end else if (note_end) begin
          tick_cnt_n = '0;
          if (note_idx == TIE_END) state_n = ST_GAP;
          else note_idx_n = note_idx + I_ONE;
        end else begin
          tick_cnt_n = tick_inc;
        end
      end
      ST_WIN: begin
        tone       = rom_tone(WIN_ROM, note_idx);
        pend_win_n = 1'b0;
        pend_tie_n = 1'b0;
        if (note_end) begin
          tick_cnt_n = '0;
          if (note_idx == WIN_END) state_n = ST_GAP;
          else note_idx_n = note_idx + I_ONE;
        end else begin
          tick_cnt_n = tick_inc;
        end
      end
      ST_GAP: begin
        if (pend_win)      state_n = ST_WIN;
        else if (pend_tie) state_n = ST_TIE;
        else if (gap_end)
          state_n = bus.song_en ? ST_SONG : ST_IDLE;
        else tick_cnt_n = tick_inc;
      end
      default: state_n = ST_IDLE;
    endcase

    // Every owner change starts from a clean note.
    if (state_n != state) begin
      tick_cnt_n = '0;
      note_idx_n = '0;
      if (state_n == ST_WIN) begin
        pend_win_n = 1'b0;
        pend_tie_n = 1'b0;
      end
      if (state_n == ST_TIE) pend_tie_n = 1'b0;
    end
  end

  always_comb begin
    grant = GR_NONE;
    busy  = 1'b0;
    unique case (1'b1)
      state == ST_SONG: grant = GR_SONG;
      state == ST_TIE: begin
        grant = GR_TIE;
        busy  = 1'b1;
      end
      state == ST_WIN: begin
        grant = GR_WIN;
        busy  = 1'b1;
      end
      state == ST_GAP: busy = 1'b1;
      default: grant = GR_NONE;
    endcase
  end

  sound_arbiter_tone_gen #(
    .HALF_UNIT(HALF_UNIT)
  ) u_tone_gen (
    .clk  (clk),
    .rst  (rst),
    .tone (tone),
    .sound(bus.sound)
  );

  assign bus.song_adv = adv_q;
  assign bus.grant    = grant;
  assign bus.busy     = busy;

endmodule

// File: tb/tb_sound_arbiter.sv
// Self-checking bench for sound_arbiter: grant sequences and
// intervals are queued as stimulus goes in and popped on output.
module tb_sound_arbiter;
  import sound_arbiter_pkg::*;

  localparam int HU = 4;
  localparam int NT = 4;
  localparam int GT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  sound_arbiter_if bus();

  sound_arbiter #(
    .HALF_UNIT (HU),
    .NOTE_TICKS(NT),
    .GAP_TICKS (GT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    bus.slowen = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.slowen = (cyc % 4 == 0);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];

  int tick_g[4];
  int tog_g[4];
  int gap_ticks, adv_n, hi_n, seen_tie;
  int last_tog, last_adv;
  bit tog;
  logic prev_snd = 1'b0;
  logic [1:0] prev_g = 2'd0;

  task automatic clear_stats();
    for (int i = 0; i < 4; i++) begin
      tick_g[i] = 0;
      tog_g[i]  = 0;
    end
    gap_ticks = 0;
    adv_n     = 0;
    hi_n      = 0;
    seen_tie  = 0;
  endtask

  // One cycle: advance to the negedge and accumulate observations.
  task automatic step();
    @(negedge clk);
    if (bus.slowen) begin
      tick_g[bus.grant] += 1;
      if (bus.grant == 2'd0 && bus.busy) gap_ticks += 1;
    end
    tog = (bus.sound !== prev_snd);
    if (tog) begin
      last_tog = cyc;
      if (prev_g == bus.grant) tog_g[bus.grant] += 1;
    end
    if (bus.song_adv) begin
      adv_n += 1;
      last_adv = cyc;
    end
    if (bus.sound) hi_n += 1;
    if (bus.grant == 2'd2) seen_tie += 1;
    prev_snd = bus.sound;
    prev_g   = bus.grant;
  endtask

  task automatic wait_toggle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (tog) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_adv(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (bus.song_adv) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_grant(
    input int budget, output logic [1:0] g, output bit ok
  );
    logic [1:0] g0;
    g0 = prev_g;
    g  = g0;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (bus.grant !== g0) begin
        g  = bus.grant;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse(input bit w, input bit t);
    bus.win_req = w;
    bus.tie_req = t;
    step();
    bus.win_req = 1'b0;
    bus.tie_req = 1'b0;
  endtask

  task automatic test_reset();
    bus.win_req = 1'b0;
    bus.tie_req = 1'b0;
    bus.song_en = 1'b0;
    bus.song_tone = '0;
    rst = 1'b1;
    repeat (3) step();
    n_cmp++;
    if ({bus.grant, bus.sound, bus.busy, bus.song_adv} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_outs: got %b want 00000",
        {bus.grant, bus.sound, bus.busy, bus.song_adv});
    end
    rst = 1'b0;
    clear_stats();
    repeat (200) step();
    n_cmp++;
    if (adv_n !== 0) begin
      n_bad++;
      $display("FAIL idle_adv: got %0d want 0", adv_n);
    end
    n_cmp++;
    if (hi_n !== 0) begin
      n_bad++;
      $display("FAIL idle_sound: got %0d want 0", hi_n);
    end
    n_cmp++;
    if (bus.grant !== 2'd0) begin
      n_bad++;
      $display("FAIL idle_grant: got %0d want 0", bus.grant);
    end
  endtask

  task automatic test_song();
    bit ok;
    int t0, e;
    bus.song_tone = 4'd3;
    bus.song_en = 1'b1;
    repeat (3) step();
    n_cmp++;
    if (bus.grant !== 2'd1) begin
      n_bad++;
      $display("FAIL song_grant: got %0d want 1", bus.grant);
    end
    wait_toggle(40, ok);
    t0 = last_tog;
    repeat (3) exp_q.push_back(3 * HU);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_toggle(60, ok);
      n_cmp++;
      if (!ok || last_tog - t0 != e) begin
        n_bad++;
        $display("FAIL song_half: got %0d want %0d",
          ok ? last_tog - t0 : -1, e);
      end
      t0 = last_tog;
    end
    wait_adv(40, ok);
    t0 = last_adv;
    repeat (2) exp_q.push_back(4 * NT);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_adv(60, ok);
      n_cmp++;
      if (!ok || last_adv - t0 != e) begin
        n_bad++;
        $display("FAIL song_adv_period: got %0d want %0d",
          ok ? last_adv - t0 : -1, e);
      end
      t0 = last_adv;
    end
  endtask

  task automatic test_win_preempt();
    bit ok;
    int e;
    logic [1:0] g;
    repeat (5) step();
    clear_stats();
    exp_q.push_back(3);
    exp_q.push_back(0);
    exp_q.push_back(1);
    pulse(1'b1, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_grant(200, g, ok);
      n_cmp++;
      if (!ok || int'(g) != e) begin
        n_bad++;
        $display("FAIL win_grant_seq: got %0d want %0d",
          ok ? int'(g) : -1, e);
      end
    end
    n_cmp++;
    if (tick_g[3] !== WIN_LEN * NT) begin
      n_bad++;
      $display("FAIL win_ticks: got %0d want %0d",
        tick_g[3], WIN_LEN * NT);
    end
    n_cmp++;
    if (gap_ticks !== GT) begin
      n_bad++;
      $display("FAIL win_gap_ticks: got %0d want %0d", gap_ticks, GT);
    end
    n_cmp++;
    if (adv_n !== 0) begin
      n_bad++;
      $display("FAIL win_no_adv: got %0d want 0", adv_n);
    end
    // Only the 12-clk last note completes a half-period in 16 clks.
    n_cmp++;
    if (tog_g[3] !== 1) begin
      n_bad++;
      $display("FAIL win_toggles: got %0d want 1", tog_g[3]);
    end
  endtask

  task automatic test_tone_rest();
    bit ok;
    bus.song_tone = 4'd0;
    wait_adv(40, ok);
    clear_stats();
    repeat (64) step();
    n_cmp++;
    if (hi_n !== 0) begin
      n_bad++;
      $display("FAIL rest_sound: got %0d want 0", hi_n);
    end
    n_cmp++;
    if (adv_n !== 4) begin
      n_bad++;
      $display("FAIL rest_adv: got %0d want 4", adv_n);
    end
  endtask

  task automatic test_tone_change();
    bit ok;
    int t0, e;
    bus.song_tone = 4'd3;
    wait_toggle(40, ok);
    bus.song_tone = 4'd5;
    // Interval counted from the first edge that samples the new code.
    t0 = cyc + 1;
    exp_q.push_back(5 * HU);
    exp_q.push_back(5 * HU);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_toggle(60, ok);
      n_cmp++;
      if (!ok || last_tog - t0 != e) begin
        n_bad++;
        $display("FAIL tone_change: got %0d want %0d",
          ok ? last_tog - t0 : -1, e);
      end
      t0 = last_tog;
    end
    bus.song_en = 1'b0;
    repeat (3) step();
    n_cmp++;
    if (bus.grant !== 2'd0) begin
      n_bad++;
      $display("FAIL song_off: got %0d want 0", bus.grant);
    end
  endtask

  task automatic test_tie();
    bit ok;
    int e;
    logic [1:0] g;
    clear_stats();
    exp_q.push_back(2);
    exp_q.push_back(0);
    pulse(1'b0, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_grant(200, g, ok);
      n_cmp++;
      if (!ok || int'(g) != e) begin
        n_bad++;
        $display("FAIL tie_grant_seq: got %0d want %0d",
          ok ? int'(g) : -1, e);
      end
    end
    wait_idle(100, ok);
    n_cmp++;
    if (!ok || bus.grant !== 2'd0) begin
      n_bad++;
      $display("FAIL tie_to_idle: got %0d want 0", bus.grant);
    end
    n_cmp++;
    if (tick_g[2] !== TIE_LEN * NT) begin
      n_bad++;
      $display("FAIL tie_ticks: got %0d want %0d",
        tick_g[2], TIE_LEN * NT);
    end
    n_cmp++;
    if (gap_ticks !== GT) begin
      n_bad++;
      $display("FAIL tie_gap_ticks: got %0d want %0d", gap_ticks, GT);
    end
    n_cmp++;
    if (hi_n !== 0) begin
      n_bad++;
      $display("FAIL tie_sound: got %0d want 0", hi_n);
    end
  endtask

  task automatic test_win_in_tie();
    bit ok;
    int e;
    logic [1:0] g;
    clear_stats();
    exp_q.push_back(2);
    exp_q.push_back(3);
    exp_q.push_back(0);
    pulse(1'b0, 1'b1);
    e = exp_q.pop_front();
    wait_grant(20, g, ok);
    n_cmp++;
    if (!ok || int'(g) != e) begin
      n_bad++;
      $display("FAIL tw_enter: got %0d want %0d", g, e);
    end
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      step();
      ok = (tick_g[2] >= NT + 1);
    end
    n_cmp++;
    if (!ok || bus.grant !== 2'd2) begin
      n_bad++;
      $display("FAIL tw_silence: got %0d want 2", bus.grant);
    end
    pulse(1'b1, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_grant(200, g, ok);
      n_cmp++;
      if (!ok || int'(g) != e) begin
        n_bad++;
        $display("FAIL tw_grant_seq: got %0d want %0d",
          ok ? int'(g) : -1, e);
      end
    end
    wait_idle(100, ok);
    n_cmp++;
    if (tick_g[3] !== WIN_LEN * NT) begin
      n_bad++;
      $display("FAIL tw_win_ticks: got %0d want %0d",
        tick_g[3], WIN_LEN * NT);
    end
    n_cmp++;
    if (tog_g[3] !== 1) begin
      n_bad++;
      $display("FAIL tw_toggles: got %0d want 1", tog_g[3]);
    end
  endtask

  task automatic test_simultaneous();
    bit ok;
    int e;
    logic [1:0] g;
    clear_stats();
    exp_q.push_back(3);
    exp_q.push_back(0);
    pulse(1'b1, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_grant(200, g, ok);
      n_cmp++;
      if (!ok || int'(g) != e) begin
        n_bad++;
        $display("FAIL both_grant_seq: got %0d want %0d",
          ok ? int'(g) : -1, e);
      end
    end
    wait_idle(100, ok);
    repeat (60) step();
    n_cmp++;
    if (seen_tie !== 0) begin
      n_bad++;
      $display("FAIL both_no_tie: got %0d want 0", seen_tie);
    end
  endtask

  task automatic test_tie_during_win();
    bit ok;
    int e;
    logic [1:0] g;
    clear_stats();
    exp_q.push_back(3);
    exp_q.push_back(0);
    pulse(1'b1, 1'b0);
    e = exp_q.pop_front();
    wait_grant(20, g, ok);
    n_cmp++;
    if (!ok || int'(g) != e) begin
      n_bad++;
      $display("FAIL tdw_enter: got %0d want %0d", g, e);
    end
    repeat (10) step();
    pulse(1'b0, 1'b1);
    e = exp_q.pop_front();
    wait_grant(200, g, ok);
    n_cmp++;
    if (!ok || int'(g) != e) begin
      n_bad++;
      $display("FAIL tdw_gap: got %0d want %0d",
        ok ? int'(g) : -1, e);
    end
    wait_idle(100, ok);
    repeat (60) step();
    n_cmp++;
    if (seen_tie !== 0 || tick_g[3] !== WIN_LEN * NT) begin
      n_bad++;
      $display("FAIL tdw_ignored: got tie=%0d ticks=%0d want 0/%0d",
        seen_tie, tick_g[3], WIN_LEN * NT);
    end
  endtask

  task automatic test_reset_mid_win();
    bit ok;
    logic [1:0] g;
    pulse(1'b1, 1'b0);
    wait_grant(20, g, ok);
    repeat (20) step();
    n_cmp++;
    if (!ok || bus.grant !== 2'd3 || !bus.busy) begin
      n_bad++;
      $display("FAIL rmw_in_win: got %0d want 3", bus.grant);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.grant, bus.sound, bus.busy, bus.song_adv} !== 5'b0) begin
      n_bad++;
      $display("FAIL rmw_async: got %b want 00000",
        {bus.grant, bus.sound, bus.busy, bus.song_adv});
    end
    repeat (2) step();
    rst = 1'b0;
    clear_stats();
    repeat (60) step();
    n_cmp++;
    if (bus.grant !== 2'd0 || tick_g[3] !== 0 || hi_n !== 0) begin
      n_bad++;
      $display("FAIL rmw_residue: got g=%0d win=%0d hi=%0d want 0",
        bus.grant, tick_g[3], hi_n);
    end
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_song();
    test_win_preempt();
    test_tone_rest();
    test_tone_change();
    test_tie();
    test_win_in_tie();
    test_simultaneous();
    test_tie_during_win();
    test_reset_mid_win();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_bad);
    $finish;
  end

endmodule
